// File: rtl/fetch_line_buffer_if.sv
// Fetch line buffer bus: the pipeline request/response signals and the
// instruction-memory line port, bundled together.
// slave  : the fetch line buffer itself
// master : the environment (pipeline PC stage plus instruction memory)
interface fetch_line_buffer_if;
  logic [31:0]  pc;
  logic         fetch_req;
  logic         flush;
  logic [31:0]  instr;
  logic         instr_valid;
  logic [31:0]  mem_addr;
  logic [127:0] mem_line;
  logic         busy;

  modport slave (
    input  pc, fetch_req, flush, mem_line,
    output instr, instr_valid, mem_addr, busy
  );

  modport master (
    output pc, fetch_req, flush, mem_line,
    input  instr, instr_valid, mem_addr, busy
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// Instruction-fetch line buffer. Holds one 16-byte line from the
// fixed-latency instruction memory and serves 32-bit big-endian words
// from it. FETCH_PERF_EN adds hit_count/miss_count performance counters.
//
// state | meaning
// IDLE  | serving hits from line_buf; a miss issues a fill
// FILL  | mem_addr held, waiting FILL_WAIT edges to sample mem_line
module fetch_line_buffer #(
  parameter int FILL_WAIT = 6
) (
  input  logic clock,
  input  logic reset_n,
  fetch_line_buffer_if.slave bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;
  localparam logic [3:0] FILL_WAIT_C = 4'(FILL_WAIT);

  logic [0:0]   state;
  logic [127:0] line_buf;
  logic [27:0]  tag;
  logic         line_valid;
  logic [3:0]   fill_cnt;
  logic [31:0]  instr_q;
  logic         instr_valid_q;
  logic [31:0]  mem_addr_q;

  logic [27:0]  pc_line;
  logic         tag_match;
  logic         same_fill;
  logic         hit;
  logic         issue;
  logic         capture;
  logic         unused_pc_bits;

  // Word k of a line, byte 4k being the most significant byte.
  function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] k);
    logic [31:0] w;
    w = line[{k, 5'd0} +: 32];
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign pc_line        = bus.pc[31:4];
  assign tag_match      = line_valid && (pc_line == tag);
  assign same_fill      = (pc_line == mem_addr_q[31:4]);
  assign unused_pc_bits = ^bus.pc[1:0];

  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.busy        = (state == ST_FILL);

  // Classify this cycle: buffer hit, fill issue (miss or restart), or fill capture.
  always_comb begin
    hit     = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    if (!bus.flush && state == ST_IDLE && bus.fetch_req) begin
      hit   = tag_match;
      issue = !tag_match;
    end else if (!bus.flush && state == ST_FILL) begin
      issue   = bus.fetch_req && !same_fill;
      capture = !issue && (fill_cnt + 4'd1 == FILL_WAIT_C);
    end
  end

  // Sequencer, buffer and output registers; flush overrides everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      line_buf      <= '0;
      tag           <= '0;
      line_valid    <= 1'b0;
      fill_cnt      <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      instr_valid_q <= 1'b0;
      if (bus.flush) begin
        state      <= ST_IDLE;
        line_valid <= 1'b0;
      end else begin
        if (hit) begin
          instr_q       <= sel_word(line_buf, bus.pc[3:2]);
          instr_valid_q <= 1'b1;
        end
        if (issue) begin
          mem_addr_q <= {pc_line, 4'b0000};
          fill_cnt   <= '0;
          state      <= ST_FILL;
        end else if (state == ST_FILL) begin
          fill_cnt <= fill_cnt + 4'd1;
          if (capture) begin
            line_buf   <= bus.mem_line;
            tag        <= mem_addr_q[31:4];
            line_valid <= 1'b1;
            state      <= ST_IDLE;
            // A pending request here is necessarily for the line being captured.
            if (bus.fetch_req) begin
              instr_q       <= sel_word(bus.mem_line, bus.pc[3:2]);
              instr_valid_q <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Count delivered instructions and issued fills (restarts included).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (instr_valid_q) hit_count <= hit_count + 16'd1;
      if (issue)         miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Bench for fetch_line_buffer: directed scenarios plus a randomized
// request stream checked against a transaction-level buffer model.
module tb_fetch_line_buffer;
  localparam int FW = 6;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] mem_bytes [0:1023];

  fetch_line_buffer_if bif ();

`ifdef FETCH_PERF_EN
  logic [15:0] hit_count, miss_count;
`endif

  fetch_line_buffer #(.FILL_WAIT(FW)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bif)
`ifdef FETCH_PERF_EN
    , .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  // Instruction memory: returns the line addressed by mem_addr (1 KB, aliased).
  always_comb begin
    bif.mem_line = '0;
    for (int n = 0; n < 16; n++)
      bif.mem_line[8*n +: 8] = mem_bytes[{bif.mem_addr[9:4], 4'(n)}];
  end

  function automatic logic [31:0] exp_word(input logic [31:0] p);
    logic [9:0] a;
    a = {p[9:2], 2'b00};
    return {mem_bytes[a], mem_bytes[a + 10'd1], mem_bytes[a + 10'd2], mem_bytes[a + 10'd3]};
  endfunction

  // Issue one request and hold it until delivery; reports edges taken (0 = timeout).
  task automatic run_req(input logic [31:0] p, output int lat, output logic [31:0] w,
                         output logic [31:0] ma, output int nbusy);
    lat = 0; w = '0; ma = '0; nbusy = 0;
    bif.pc = p;
    bif.fetch_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (n == 1) ma = bif.mem_addr;
      if (bif.busy) nbusy++;
      if (bif.instr_valid) begin
        lat = n;
        w = bif.instr;
        break;
      end
    end
    bif.fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (bif.instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bif.instr); end
    n_checks++; if (bif.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bif.instr_valid); end
    n_checks++; if (bif.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bif.mem_addr); end
    n_checks++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
`ifdef FETCH_PERF_EN
    n_checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
  endtask

  task automatic test_cold_miss();
    int lat, nb; logic [31:0] w, ma;
    run_req(32'h0, lat, w, ma, nb);
    n_checks++; if (ma !== 32'h0) begin n_fail++; $display("FAIL cold_mem_addr: got %h want 0", ma); end
    n_checks++; if (nb !== FW) begin n_fail++; $display("FAIL cold_busy_cycles: got %0d want %0d", nb, FW); end
    n_checks++; if (lat !== FW + 1) begin n_fail++; $display("FAIL cold_latency: got %0d want %0d", lat, FW + 1); end
    n_checks++; if (w !== 32'h00430800) begin n_fail++; $display("FAIL cold_instr: got %h want 00430800", w); end
    @(posedge clock); #1;
    n_checks++; if (bif.instr_valid !== 1'b0) begin n_fail++; $display("FAIL cold_single_pulse: got %b want 0", bif.instr_valid); end
  endtask

  task automatic test_hits();
    logic [31:0] hv [3];
    hv = '{32'h00a62001, 32'h01093802, 32'h016c5003};
    bif.pc = 32'h4;
    bif.fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      n_checks++; if (bif.instr_valid !== 1'b1) begin n_fail++; $display("FAIL hit_valid[%0d]: got %b want 1", i, bif.instr_valid); end
      n_checks++; if (bif.instr !== hv[i]) begin n_fail++; $display("FAIL hit_instr[%0d]: got %h want %h", i, bif.instr, hv[i]); end
      n_checks++; if (bif.mem_addr !== 32'h0) begin n_fail++; $display("FAIL hit_mem_addr[%0d]: got %h want 0", i, bif.mem_addr); end
      n_checks++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL hit_busy[%0d]: got %b want 0", i, bif.busy); end
      if (i < 2) bif.pc = 32'(4 * (i + 2));
      else bif.fetch_req = 1'b0;
    end
    @(posedge clock); #1;
`ifdef FETCH_PERF_EN
    n_checks++; if (miss_count !== 16'd1) begin n_fail++; $display("FAIL perf_miss: got %0d want 1", miss_count); end
    n_checks++; if (hit_count !== 16'd4) begin n_fail++; $display("FAIL perf_hit: got %0d want 4", hit_count); end
`endif
  endtask

  task automatic test_restart();
    int lat, nb; logic [31:0] w, ma;
    bif.pc = 32'h20;
    bif.fetch_req = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clock); #1;
      n_checks++; if (bif.mem_addr !== 32'h20 || bif.busy !== 1'b1) begin n_fail++; $display("FAIL restart_first_fill[%0d]: got %h/%b want 00000020/1", e, bif.mem_addr, bif.busy); end
    end
    bif.pc = 32'h30;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (n == 1) begin
        n_checks++; if (bif.mem_addr !== 32'h30) begin n_fail++; $display("FAIL restart_mem_addr: got %h want 00000030", bif.mem_addr); end
      end
      if (bif.instr_valid) begin lat = n; break; end
    end
    bif.fetch_req = 1'b0;
    n_checks++; if (lat !== FW + 1) begin n_fail++; $display("FAIL restart_latency: got %0d want %0d", lat, FW + 1); end
    n_checks++; if (bif.instr !== 32'h1800fff3) begin n_fail++; $display("FAIL restart_instr: got %h want 1800fff3", bif.instr); end
    run_req(32'h34, lat, w, ma, nb);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL restart_tag_hit_latency: got %0d want 1", lat); end
    n_checks++; if (w !== exp_word(32'h34)) begin n_fail++; $display("FAIL restart_tag_hit_instr: got %h want %h", w, exp_word(32'h34)); end
  endtask

  task automatic test_flush();
    int lat, nb, pulses; logic [31:0] w, ma, held;
    held = bif.instr;
    bif.pc = 32'h40;
    bif.fetch_req = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (bif.busy !== 1'b1) begin n_fail++; $display("FAIL flush_fill_started: got %b want 1", bif.busy); end
    @(posedge clock); #1;
    bif.fetch_req = 1'b0;
    bif.flush = 1'b1;
    @(posedge clock); #1;
    bif.flush = 1'b0;
    n_checks++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", bif.busy); end
    n_checks++; if (bif.mem_addr !== 32'h40) begin n_fail++; $display("FAIL flush_mem_addr_kept: got %h want 00000040", bif.mem_addr); end
    n_checks++; if (bif.instr !== held) begin n_fail++; $display("FAIL flush_instr_kept: got %h want %h", bif.instr, held); end
    pulses = 0;
    for (int e = 0; e < FW + 2; e++) begin
      @(posedge clock); #1;
      if (bif.instr_valid) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL flush_no_delivery: got %0d pulses want 0", pulses); end
    bif.pc = 32'h0;
    run_req(32'h0, lat, w, ma, nb);
    bif.pc = 32'h4;
    bif.fetch_req = 1'b1;
    bif.flush = 1'b1;
    @(posedge clock); #1;
    bif.fetch_req = 1'b0;
    bif.flush = 1'b0;
    n_checks++; if (bif.instr_valid !== 1'b0 || bif.busy !== 1'b0) begin n_fail++; $display("FAIL flush_with_req: got valid %b busy %b want 0/0", bif.instr_valid, bif.busy); end
    run_req(32'h0, lat, w, ma, nb);
    n_checks++; if (lat !== FW + 1) begin n_fail++; $display("FAIL flush_refill_latency: got %0d want %0d", lat, FW + 1); end
    n_checks++; if (w !== 32'h00430800) begin n_fail++; $display("FAIL flush_refill_instr: got %h want 00430800", w); end
  endtask

  task automatic test_async_reset();
    int lat, nb; logic [31:0] w, ma;
    bif.pc = 32'h50;
    bif.fetch_req = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bif.busy !== 1'b0 || bif.instr_valid !== 1'b0) begin n_fail++; $display("FAIL areset_ctrl: got busy %b valid %b want 0/0", bif.busy, bif.instr_valid); end
    n_checks++; if (bif.mem_addr !== 32'h0) begin n_fail++; $display("FAIL areset_mem_addr: got %h want 0", bif.mem_addr); end
    n_checks++; if (bif.instr !== 32'h0) begin n_fail++; $display("FAIL areset_instr: got %h want 0", bif.instr); end
    bif.fetch_req = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    run_req(32'h0, lat, w, ma, nb);
    n_checks++; if (lat !== FW + 1 || nb !== FW) begin n_fail++; $display("FAIL areset_clean_fill: got lat %0d busy %0d want %0d/%0d", lat, nb, FW + 1, FW); end
    n_checks++; if (w !== 32'h00430800) begin n_fail++; $display("FAIL areset_fill_instr: got %h want 00430800", w); end
  endtask

  task automatic test_random();
    logic        m_valid;
    logic [27:0] m_tag;
    logic [31:0] p, w, ma;
    int lat, nb, exp_lat;
    m_valid = 1'b1;
    m_tag = 28'h0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        bif.flush = 1'b1;
        @(posedge clock); #1;
        bif.flush = 1'b0;
        m_valid = 1'b0;
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) begin @(posedge clock); #1; end
      p = {11'd0, 1'($urandom_range(0, 1)), 10'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      exp_lat = (m_valid && m_tag == p[31:4]) ? 1 : FW + 1;
      run_req(p, lat, w, ma, nb);
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d] pc %h: got %0d want %0d", it, p, lat, exp_lat); end
      n_checks++; if (w !== exp_word(p)) begin n_fail++; $display("FAIL rand_instr[%0d] pc %h: got %h want %h", it, p, w, exp_word(p)); end
      if (exp_lat != 1) begin
        n_checks++; if (ma !== {p[31:4], 4'b0000}) begin n_fail++; $display("FAIL rand_mem_addr[%0d]: got %h want %h", it, ma, {p[31:4], 4'b0000}); end
      end
      m_valid = 1'b1;
      m_tag = p[31:4];
    end
  endtask

  initial begin
    bif.pc = '0;
    bif.fetch_req = 1'b0;
    bif.flush = 1'b0;
    for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'($urandom);
    begin
      logic [7:0] l0 [16];
      l0 = '{8'h00, 8'h43, 8'h08, 8'h00, 8'h00, 8'ha6, 8'h20, 8'h01,
             8'h01, 8'h09, 8'h38, 8'h02, 8'h01, 8'h6c, 8'h50, 8'h03};
      for (int i = 0; i < 16; i++) mem_bytes[i] = l0[i];
    end
    mem_bytes[48] = 8'h18; mem_bytes[49] = 8'h00; mem_bytes[50] = 8'hff; mem_bytes[51] = 8'hf3;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clock); #1;
    test_cold_miss();
    test_hits();
    test_restart();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
